div_16x8_seq: RTL and testbench

Sequential radix-2 restoring divider. It is the inverse of the 8x8 multiplier family: it divides a 16-bit product-width dividend by an 8-bit operand-width divisor. It is used to recover operands from multiplier outputs and to measure relative error in the approximate-multiplier evaluation flow. Operands enter and results leave through valid/ready handshakes; one division is in flight at a time.

---
 rtl/div_16x8_seq.sv | 82 ++++++++
 tb/tb_div_16x8_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_16x8_seq.sv
// div_16x8_seq: sequential radix-2 restoring divider, DW-bit dividend by VW-bit divisor,
// with valid/ready handshakes on both sides and one division in flight at a time.
module div_16x8_seq #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);
    localparam int CW = $clog2(DW);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [DW-1:0] r_sr;
    logic [VW-1:0] r_div;
    logic [VW:0]   r_prem;
    logic [CW-1:0] r_cnt;
    logic [VW+1:0] w_shift;
    logic          w_ge;
    logic [VW:0]   w_prem;
    logic [DW-1:0] w_sr;

    // The true difference always fits in VW+1 bits, so the subtraction can be done narrow.
    always_comb begin
        w_shift = {r_prem, r_sr[DW-1]};
        w_ge    = w_shift >= {2'b00, r_div};
        w_prem  = w_shift[VW:0] - (w_ge ? {1'b0, r_div} : '0);
        w_sr    = {r_sr[DW-2:0], w_ge};
    end

    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_div       <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_sr   <= dividend;
            r_div  <= divisor;
            r_prem <= '0;
            r_cnt  <= '0;
            if (divisor == '0) begin
                r_state     <= S_DONE;
                quotient    <= '1;
                remainder   <= dividend[VW-1:0];
                div_by_zero <= 1'b1;
            end else begin
                r_state <= S_CALC;
            end
        end else if (r_state == S_CALC) begin
            r_sr   <= w_sr;
            r_prem <= w_prem;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == CW'(DW - 1)) begin
                r_state     <= S_DONE;
                quotient    <= w_sr;
                remainder   <= w_prem[VW-1:0];
                div_by_zero <= 1'b0;
            end
        end else if (r_state == S_DONE && out_ready) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_div_16x8_seq.sv
// tb_div_16x8_seq: directed and randomized checks of div_16x8_seq against a
// plain-arithmetic reference model.
module tb_div_16x8_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_chk = 0;
    int n_fail = 0;

    div_16x8_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for the result, stall, then hand it off.
    task automatic run(input logic [15:0] a, input logic [7:0] b, input int stall);
        logic [15:0] eq;
        logic [15:0] mod;
        logic [7:0]  er;
        int n;
        eq  = (b == 0) ? 16'hFFFF : a / {8'd0, b};
        mod = (b == 0) ? {8'd0, a[7:0]} : a % {8'd0, b};
        er  = mod[7:0];
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", n, (b == 0) ? 32'd0 : 32'd16);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {24'd0, remainder}, {24'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, b == 0});
        for (int i = 0; i < stall; i++) begin
            in_valid = i[0];
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_q", {16'd0, quotient}, {16'd0, eq});
            chk("hold_r", {24'd0, remainder}, {24'd0, er});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drop_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        chk("keep_q", {16'd0, quotient}, {16'd0, eq});
    endtask

    initial begin
        logic [7:0] a8;
        logic [7:0] b8;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_q", {16'd0, quotient}, 32'd0);
        chk("rst_r", {24'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        run(16'd51200, 8'd200, 0);
        run(16'd1000, 8'd7, 0);
        run(16'd65535, 8'd1, 0);
        run(16'd5, 8'd9, 0);
        run(16'd0, 8'd13, 0);
        run(16'h04D2, 8'd0, 0);
        run(16'd1000, 8'd7, 5);
        run(16'd300, 8'd3, 0);

        // Abandon an operation mid-flight; the next one must be clean.
        in_valid = 1'b1;
        dividend = 16'd51200;
        divisor  = 8'd200;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_q", {16'd0, quotient}, 32'd0);
        chk("mid_rst_r", {24'd0, remainder}, 32'd0);
        run(16'd1000, 8'd7, 0);

        // Reset wins over a same-cycle accept.
        in_valid = 1'b1;
        dividend = 16'd77;
        divisor  = 8'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_vs_accept", {31'd0, out_valid}, 32'd0);
        tick();
        chk("rst_vs_accept_idle", {31'd0, in_ready}, 32'd1);

        for (int k = 0; k < 300; k++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(1, 255));
            run({8'd0, a8} * {8'd0, b8}, b8, $urandom_range(0, 3));
        end
        for (int k = 0; k < 100; k++) begin
            b8 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run(16'($urandom), b8, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
